fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream stage of the camera packetizer.
- Buffers the packetizer's 9-bit FIFO words in an internal synchronous FIFO and drops words flagged as dummy (bit 8 = 0).
- Serializes the remaining 8-bit payload bytes onto a UART line (8N1, LSB first) toward the host PC.
- Absorbs the bursty packetizer output and paces it at the baud rate.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- ADDR_W, 4, FIFO address width; depth = 2^ADDR_W entries (default 16).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- fifo_din  in  9  word from packetizer; bit 8 = payload flag, bits 7:0 = byte.
- fifo_din_valid  in  1  fifo_din is presented this cycle.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high while a frame is being shifted (any state other than IDLE).
- fifo_full  out  1  internal FIFO holds 2^ADDR_W entries.
- fifo_empty  out  1  internal FIFO holds 0 entries.
- overflow  out  1  sticky; a payload word was dropped because the FIFO was full.
- byte_count  out  16  payload bytes fully transmitted (stop bit completed); wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst=0 at edge):
  - tx=1, busy=0, fifo_full=0, fifo_empty=1, overflow=0, byte_count=0.
  - FIFO pointers and occupancy cleared, FSM -> IDLE, baud counter=0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 the next cycle.
- Write qualification:
  - A write occurs when fifo_din_valid=1, fifo_din[8]=1 and fifo_full=0.
  - Words with fifo_din[8]=0 are discarded silently; they never set overflow.
- Overflow:
  - fifo_din_valid=1, fifo_din[8]=1 and fifo_full=1 sets overflow=1 and drops the word.
  - fullness is evaluated before any same-cycle pop; a pop in that cycle does not make room.
  - overflow clears only on reset.
- FIFO:
  - Occupancy counter is ADDR_W+1 bits; pointers wrap modulo 2^ADDR_W.
  - Simultaneous write and pop leave occupancy unchanged.
  - fifo_full and fifo_empty are registered-state decodes of occupancy.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_empty=0, pop head into an 8-bit shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles; then shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle, byte_count increments. Then:
    - if fifo_empty=0, pop at the same edge and go directly to START (no idle gap);
    - otherwise go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles per byte, with zero jitter.
- Latency: write accepted at edge N gives fifo_empty=0 after N; IDLE pops at edge N+1; tx falls at edge N+1 (visible in cycle N+1..N+2). First-byte latency is 1 idle cycle after the FIFO becomes non-empty.
- Baud counter: 16 bits; counts 0..CLKS_PER_BIT-1, and a bit ends when the count = CLKS_PER_BIT-1.
- All outputs are registered; tx has no combinational path from inputs.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles (8E1).
- Undefined:
  - No PARITY state; 8N1 framing as above.

Test Plan:
- CLKS_PER_BIT=4: single write fifo_din=9'h1A5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop), each bit 4 cycles; byte_count 0->1 after 40 cycles; busy falls after the stop bit.
- Write 9'h0FF (bit8=0) then 9'h1FF -> only 0xFF is transmitted; byte_count=1; overflow=0; fifo_empty=1 at end.
- ADDR_W=2, CLKS_PER_BIT=4: burst 6 payload words 0x01..0x06 on consecutive cycles -> first byte popped, 4 buffered, 6th dropped; fifo_full=1; overflow=1; line output is 0x01,0x02,0x03,0x04,0x05 back-to-back with no idle cycles between frames.
- Assert rst=0 during DATA bit 3 -> next cycle tx=1, busy=0, fifo_empty=1, overflow=0, byte_count=0; a post-reset write of 9'h13C transmits a clean 0x3C frame.
- Preload byte_count near wrap (send 65536 bytes with CLKS_PER_BIT=2, or force in sim) -> byte_count reads 0x0000 after the 65536th stop bit.
- UART_PARITY_EN defined: send 0x07 -> parity bit 1 after data, frame 44 cycles at CLKS_PER_BIT=4. Send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: buffers 9-bit packetizer words in a small synchronous FIFO,
// discards dummy words (bit 8 = 0), and serializes the payload bytes onto an
// 8N1 UART line, LSB first, at CLKS_PER_BIT clocks per bit.
// Optional macro UART_PARITY_EN adds an even-parity bit (8E1 framing).
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [8:0]  fifo_din,
   input  logic        fifo_din_valid,
   output logic        tx,
   output logic        busy,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic        overflow,
   output logic [15:0] byte_count
);

   localparam int              DEPTH     = 1 << ADDR_W;
   localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [ADDR_W:0] FULL_CNT  = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   // FIFO storage and bookkeeping
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count;
   logic              wr_en, pop, drop;

   // serializer state
   state_t      state, state_n;
   logic [15:0] baud, baud_n;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [7:0]  shift, shift_n;
   logic        par, par_n;
   logic        tx_n;
   logic [15:0] byte_cnt, byte_cnt_n;
   logic        bit_end;

   // Full/empty come straight off the occupancy register, so a pop in the
   // same cycle never opens a slot for a write.
   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);
   assign wr_en      = fifo_din_valid & fifo_din[8] & ~fifo_full;
   assign drop       = fifo_din_valid & fifo_din[8] & fifo_full;
   assign bit_end    = (baud == BAUD_LAST);
   assign byte_count = byte_cnt;

   // FIFO storage write; contents need no reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= fifo_din[7:0];
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) overflow <= 1'b1;
      end
   end

   // Serializer next-state, pop strobe and next line level
   always_comb begin
      state_n    = state;
      baud_n     = baud + 16'd1;
      bit_idx_n  = bit_idx;
      shift_n    = shift;
      par_n      = par;
      byte_cnt_n = byte_cnt;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            baud_n = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               par_n   = ^mem[rd_ptr];
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_n    = '0;
               bit_idx_n = '0;
               state_n   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_n    = '0;
               shift_n   = {1'b0, shift[7:1]};
               bit_idx_n = bit_idx + 3'd1;
`ifdef UART_PARITY_EN
               if (bit_idx == 3'd7) state_n = PARITY;
`else
               if (bit_idx == 3'd7) state_n = STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               baud_n  = '0;
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               baud_n     = '0;
               byte_cnt_n = byte_cnt + 16'd1;
               // chain straight into the next frame when data is waiting
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  par_n   = ^mem[rd_ptr];
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: begin
            baud_n  = '0;
            state_n = IDLE;
         end
      endcase

      // line level is a function of the state being entered, then registered
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         PARITY:  tx_n = par_n;
         default: tx_n = 1'b1;
      endcase
   end

   // Serializer state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         par      <= 1'b0;
         byte_cnt <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         baud     <= baud_n;
         bit_idx  <= bit_idx_n;
         shift    <= shift_n;
         par      <= par_n;
         byte_cnt <= byte_cnt_n;
         tx       <= tx_n;
         busy     <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a line monitor decodes UART frames and
// checks each byte against a scoreboard queue filled as payload is written.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef UART_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif

   logic        clk;
   logic        rst;
   logic [8:0]  fifo_din;
   logic        fifo_din_valid;
   logic        tx, busy, fifo_full, fifo_empty, overflow;
   logic [15:0] byte_count;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [7:0]  exp_q[$];
   int          starts[$];

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_din      (fifo_din),
      .fifo_din_valid(fifo_din_valid),
      .tx            (tx),
      .busy          (busy),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .overflow      (overflow),
      .byte_count    (byte_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // present one word for one clock, returning at the following negedge
   task automatic wr(input logic [8:0] d);
      fifo_din       = d;
      fifo_din_valid = 1'b1;
      @(negedge clk);
      fifo_din_valid = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int n;
      n = 0;
      while ((busy !== 1'b0 || fifo_empty !== 1'b1) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(n < maxc), 32'd1);
   endtask

   // line monitor: samples mid-bit, checks framing, pops the scoreboard
   int         mon_cnt;
   int         k;
   bit         mon_act;
   logic [7:0] rx_byte;
   logic [7:0] exp_b;
   initial begin
      mon_act = 1'b0;
      mon_cnt = 0;
      rx_byte = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) mon_act = 1'b0;
         else if (!mon_act) begin
            if (tx === 1'b0) begin
               mon_act = 1'b1;
               mon_cnt = 0;
               starts.push_back(cyc);
            end
         end else mon_cnt++;
         if (mon_act) begin
            if (mon_cnt % CPB == CPB / 2) begin
               k = mon_cnt / CPB;
               if (k == 0) chk("rx_start", 32'(tx), 32'd0);
               else if (k <= 8) rx_byte[k-1] = tx;
`ifdef UART_PARITY_EN
               else if (k == 9) chk("rx_parity", 32'(tx), 32'(^rx_byte));
`endif
               else chk("rx_stop", 32'(tx), 32'd1);
            end
            if (mon_cnt == FRAME * CPB - 1) begin
               mon_act = 1'b0;
               chk("rx_pending", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  exp_b = exp_q.pop_front();
                  chk("rx_byte", 32'(rx_byte), 32'(exp_b));
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   int n;
   initial begin
      rst            = 1'b0;
      fifo_din       = '0;
      fifo_din_valid = 1'b0;
      repeat (3) @(negedge clk);
      // reset state
      chk("rst_tx",       32'(tx),         32'd1);
      chk("rst_busy",     32'(busy),       32'd0);
      chk("rst_full",     32'(fifo_full),  32'd0);
      chk("rst_empty",    32'(fifo_empty), 32'd1);
      chk("rst_overflow", 32'(overflow),   32'd0);
      chk("rst_bytes",    32'(byte_count), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // single byte 0xA5: latency and frame length
      exp_q.push_back(8'hA5);
      wr(9'h1A5);
      chk("lat_empty0", 32'(fifo_empty), 32'd0);
      chk("lat_tx_idle", 32'(tx), 32'd1);
      chk("lat_busy0", 32'(busy), 32'd0);
      @(negedge clk);
      chk("lat_tx_start", 32'(tx), 32'd0);
      chk("lat_busy1", 32'(busy), 32'd1);
      chk("lat_empty1", 32'(fifo_empty), 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy === 1'b1 && n < 200);
      chk("frame_len", 32'(n), 32'(FRAME * CPB));
      chk("bytes_1", 32'(byte_count), 32'd1);

      // dummy word discarded, payload sent
      exp_q.push_back(8'hFF);
      wr(9'h0FF);
      wr(9'h1FF);
      wait_idle(200);
      chk("bytes_2", 32'(byte_count), 32'd2);
      chk("dummy_ovf", 32'(overflow), 32'd0);
      chk("dummy_empty", 32'(fifo_empty), 32'd1);

      // burst of six into a 4-deep FIFO: sixth dropped, frames back-to-back
      starts.delete();
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
      for (int i = 1; i <= 6; i++) wr({1'b1, 8'(i)});
      chk("burst_full", 32'(fifo_full), 32'd1);
      chk("burst_ovf", 32'(overflow), 32'd1);
      wait_idle(6 * FRAME * CPB);
      chk("bytes_7", 32'(byte_count), 32'd7);
      chk("burst_frames", 32'(starts.size()), 32'd5);
      if (starts.size() == 5)
         for (int i = 1; i < 5; i++)
            chk("burst_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME * CPB));

      // reset during data bit 3 aborts the frame
      exp_q.push_back(8'h55);
      wr(9'h155);
      @(negedge clk);
      repeat (17) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_tx",    32'(tx),         32'd1);
      chk("mid_rst_busy",  32'(busy),       32'd0);
      chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
      chk("mid_rst_ovf",   32'(overflow),   32'd0);
      chk("mid_rst_bytes", 32'(byte_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      exp_q.push_back(8'h3C);
      wr(9'h13C);
      wait_idle(200);
      chk("post_rst_bytes", 32'(byte_count), 32'd1);

      // byte counter wrap
      force dut.byte_cnt = 16'hFFFE;
      @(posedge clk);
      @(negedge clk);
      release dut.byte_cnt;
      @(negedge clk);
      chk("wrap_preload", 32'(byte_count), 32'hFFFE);
      exp_q.push_back(8'h81);
      wr(9'h181);
      wait_idle(200);
      chk("wrap_ffff", 32'(byte_count), 32'hFFFF);
      exp_q.push_back(8'h42);
      wr(9'h142);
      wait_idle(200);
      chk("wrap_zero", 32'(byte_count), 32'h0000);

`ifdef UART_PARITY_EN
      // parity: 0x07 -> 1, 0x03 -> 0 (checked by the monitor)
      exp_q.push_back(8'h07);
      exp_q.push_back(8'h03);
      wr(9'h107);
      wr(9'h103);
      wait_idle(400);
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
